pong_match_ctrl: RTL

//   Match-level sequencer for the Pong game. Gates ball motion, times the

---
 rtl/pong_match_ctrl_pkg.sv | 16 +
 rtl/pong_match_ctrl_serve_timer.sv | 28 ++
 rtl/pong_match_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pong_match_ctrl_pkg.sv
// Shared definitions for the Pong match sequencer: FSM state encodings
// and serve direction values.
package pong_match_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/pong_match_ctrl_serve_timer.sv
// Frame counter for the pause before a serve: counts enabled frame ticks
// and flags the last frame of the serve delay.
module pong_match_ctrl_serve_timer #(
    parameter int DLY_W        = 7,
    parameter int SERVE_FRAMES = 60
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic terminal
);

    logic [DLY_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == DLY_W'(SERVE_FRAMES - 1));

endmodule

// File: rtl/pong_match_ctrl.sv
// Match-level sequencer for Pong: gates ball motion, times the serve pause,
// keeps both scores and declares the winner.
//
// state | meaning
// IDLE  | waiting for start, ball held at centre
// SERVE | ball at centre, counting frames before release
// PLAY  | ball moving, watching for misses
// POINT | one cycle to award the point and pick the next state
// OVER  | match finished, scores and winner held
module pong_match_ctrl
    import pong_match_ctrl_pkg::*;
#(
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int DLY_W        = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               ball_en,
    output logic               ball_home,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               point_pulse,
    output logic               game_over,
    output logic               winner
);

    state_t state, state_nx;

    logic               timer_clr, timer_en, timer_done;
    logic               scorer_q, scorer_nx;  // 1 = right player scored
    logic [SCORE_W-1:0] score_l_nx, score_r_nx;
    logic [SCORE_W-1:0] base_score, inc_score;
    logic               serve_dir_nx, winner_nx;

    assign timer_en  = (state == ST_SERVE) && frame_tick;
    assign timer_clr = (state != ST_SERVE) || (frame_tick && timer_done);

    pong_match_ctrl_serve_timer #(
        .DLY_W       (DLY_W),
        .SERVE_FRAMES(SERVE_FRAMES)
    ) u_serve_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .terminal(timer_done)
    );

    always_comb begin
        state_nx     = state;
        score_l_nx   = score_l;
        score_r_nx   = score_r;
        serve_dir_nx = serve_dir;
        winner_nx    = winner;
        scorer_nx    = scorer_q;
        base_score   = scorer_q ? score_r : score_l;
        inc_score    = (base_score >= SCORE_W'(WIN_SCORE)) ? SCORE_W'(WIN_SCORE)
                                                           : base_score + 1'b1;
        case (state)
            ST_IDLE: begin
                if (start_btn) begin
                    state_nx   = ST_SERVE;
                    score_l_nx = '0;
                    score_r_nx = '0;
                end
            end
            ST_SERVE: begin
                if (frame_tick && timer_done) state_nx = ST_PLAY;
            end
            ST_PLAY: begin
                // simultaneous misses are a replay, not a point
                if (miss_left && miss_right) begin
                    state_nx = ST_SERVE;
                end else if (miss_left) begin
                    state_nx  = ST_POINT;
                    scorer_nx = 1'b1;
                end else if (miss_right) begin
                    state_nx  = ST_POINT;
                    scorer_nx = 1'b0;
                end
            end
            ST_POINT: begin
                if (scorer_q) begin
                    score_r_nx   = inc_score;
                    serve_dir_nx = DIR_LEFT;
                end else begin
                    score_l_nx   = inc_score;
                    serve_dir_nx = DIR_RIGHT;
                end
                if (inc_score == SCORE_W'(WIN_SCORE)) begin
                    state_nx  = ST_OVER;
                    winner_nx = scorer_q;
                end else begin
                    state_nx = ST_SERVE;
                end
            end
            ST_OVER: begin
                if (start_btn) begin
                    state_nx     = ST_SERVE;
                    score_l_nx   = '0;
                    score_r_nx   = '0;
                    serve_dir_nx = DIR_LEFT;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            score_l     <= '0;
            score_r     <= '0;
            serve_dir   <= DIR_LEFT;
            winner      <= 1'b0;
            scorer_q    <= 1'b0;
            ball_en     <= 1'b0;
            ball_home   <= 1'b1;
            point_pulse <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_nx;
            score_l     <= score_l_nx;
            score_r     <= score_r_nx;
            serve_dir   <= serve_dir_nx;
            winner      <= winner_nx;
            scorer_q    <= scorer_nx;
            ball_en     <= (state_nx == ST_PLAY);
            ball_home   <= (state_nx == ST_IDLE) || (state_nx == ST_SERVE) ||
                           (state_nx == ST_OVER);
            point_pulse <= (state == ST_POINT);
            game_over   <= (state_nx == ST_OVER);
        end
    end

endmodule
